wb_commit_ctrl: RTL and testbench
=================================

Name: wb_commit_ctrl

Overview:
- Writeback-stage commit controller; consumes MEM/WB latch outputs (o, d, ir, ovf) and multdiv completions.
- Produces the single registered register-file write port, the forwarding copy of that write, and a stall back to the MEM/WB latch.
- Arbitrates same-cycle pipeline and multdiv writes with a one-entry hold buffer and a 2-state FSM.

Parameters:
- WIDTH, 32, data width.
- AW, 5, register address width.
- STATUS_REG, 30, $rstatus index.
- LINK_REG, 31, jal link register index.

Ports:
- clock  in  1  rising-edge clock.
- resetn  in  1  asynchronous, active-low reset.
- mw_o  in  WIDTH  ALU result / PC+1 from MEM/WB latch.
- mw_d  in  WIDTH  load data from MEM/WB latch.
- mw_ir  in  32  instruction from MEM/WB latch.
- mw_ovf  in  1  ALU overflow from MEM/WB latch.
- md_valid  in  1  multdiv result ready, single-cycle pulse.
- md_result  in  WIDTH  multdiv result.
- md_exc  in  1  multdiv exception.
- md_rd  in  AW  multdiv destination register.
- md_is_div  in  1  1 = div, 0 = mult.
- rf_we  out  1  register-file write enable, registered.
- rf_waddr  out  AW  write address, registered.
- rf_wdata  out  WIDTH  write data, registered.
- wb_stall  out  1  freeze MEM/WB latch and upstream.

Behaviour:
- Reset (resetn=0, async): rf_we=0, rf_waddr=0, rf_wdata=0, state=IDLE, wb_stall=0, hold buffer invalid with zero contents.
- Pipeline decode; opcode = ir[31:27], rd = ir[26:22], aluop = ir[6:2]:
  - R-type 00000: addr rd, data o. If ovf: add (aluop 00000) -> addr STATUS_REG, data 1; sub (00001) -> addr STATUS_REG, data 3.
  - mul/div aluops (00110/00111) in an R-type: no pipeline write; the result arrives via md_*.
  - addi 00101: addr rd, data o. If ovf -> addr STATUS_REG, data 2.
  - lw 01000: addr rd, data d.
  - jal 00011: addr LINK_REG, data o.
  - setx 10101: addr STATUS_REG, data zero-extended ir[26:0].
  - All other opcodes: no write.
- Multdiv write: addr md_rd, data md_result. If md_exc: addr STATUS_REG, data 4 (mult) or 5 (div).
- Any write whose final addr is 0 is dropped (rf_we stays 0). Status/link redirects are never dropped.
- Latency: the candidate write for cycle N appears on rf_* during cycle N+1. rf_we is high for exactly one cycle per committed write.
- FSM IDLE:
  - Only pipeline write, or only md_valid: commit it.
  - Both in the same cycle: commit the md write; capture the pipeline write in the hold buffer; go to HOLD.
  - Neither: rf_we=0; rf_waddr and rf_wdata hold their previous values.
- FSM HOLD:
  - wb_stall=1 (wb_stall = state==HOLD, glitch-free). mw_* inputs are ignored; the MEM/WB latch holds them and they are reprocessed in the next IDLE cycle.
  - md_valid=0: commit the buffered write; invalidate the buffer; go to IDLE.
  - md_valid=1: commit the md write; keep the buffer; stay in HOLD.
- Reset asserted mid-HOLD: the buffered write is discarded and no write is emitted.
- A STATUS_REG write from an overflow or exception fully replaces any pending rd write of the same instruction.

Decomposition:
- Shared package: opcode and aluop constants (OP_RTYPE, OP_ADDI, OP_LW, OP_JAL, OP_SETX, ALU_ADD, ALU_SUB, ALU_MUL, ALU_DIV), status codes 1–5, FSM state encoding (1 bit).
- Sub-module wb_decode (combinational): mw_ir, mw_o, mw_d, mw_ovf -> {we, addr, data}.
- The FSM, hold buffer and output registers stay in the top level, built on dffe_ref-style flops.

Test Plan:
- add $3 with o=0x0000_0007, ovf=0 -> next cycle rf_we=1, waddr=3, wdata=7. Same instruction with ovf=1 -> waddr=30, wdata=1.
- lw $5 with d=0xDEAD_BEEF; then addi $0 -> write waddr=5, wdata=0xDEADBEEF; then rf_we=0 for the $0 write.
- Same cycle: jal (o=0x40) and md_valid (rd=7, result=42) -> C+1: waddr=7, wdata=42, wb_stall=1. C+2: waddr=31, wdata=0x40, wb_stall=0.
- Same conflict as above, plus md_valid again in HOLD (rd=8, result=9) -> writes rd 7, then rd 8, then rd 31; wb_stall high for 2 cycles.
- div with md_exc=1 -> waddr=30, wdata=5. setx with ir[26:0]=0x123 -> waddr=30, wdata=0x123.
- Drop resetn during HOLD -> rf_we=0 immediately, wb_stall=0; buffered jal is never written after reset release.

Source files
------------

// File: rtl/wb_commit_ctrl_pkg.sv
// Shared definitions for the writeback commit controller.
//   - opcode / aluop encodings decoded from the MEM/WB instruction
//   - status codes written to $rstatus on overflow / multdiv exception
//   - commit FSM state encoding
package wb_commit_ctrl_pkg;

   localparam logic [4:0] OP_RTYPE = 5'b00000;
   localparam logic [4:0] OP_ADDI  = 5'b00101;
   localparam logic [4:0] OP_LW    = 5'b01000;
   localparam logic [4:0] OP_JAL   = 5'b00011;
   localparam logic [4:0] OP_SETX  = 5'b10101;

   localparam logic [4:0] ALU_ADD  = 5'b00000;
   localparam logic [4:0] ALU_SUB  = 5'b00001;
   localparam logic [4:0] ALU_MUL  = 5'b00110;
   localparam logic [4:0] ALU_DIV  = 5'b00111;

   localparam int unsigned ST_ADD_OVF  = 1;
   localparam int unsigned ST_ADDI_OVF = 2;
   localparam int unsigned ST_SUB_OVF  = 3;
   localparam int unsigned ST_MUL_EXC  = 4;
   localparam int unsigned ST_DIV_EXC  = 5;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

endpackage

// File: rtl/wb_decode.sv
// Combinational decode of the MEM/WB latch into a candidate register write.
// Ports:
//   mw_ir, mw_o, mw_d, mw_ovf : MEM/WB latch outputs
//   we, addr, data            : candidate write; we is already cleared for
//                               writes whose final address is $0
module wb_decode
   import wb_commit_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned AW         = 5,
   parameter int unsigned STATUS_REG = 30,
   parameter int unsigned LINK_REG   = 31
) (
   input  logic [31:0]      mw_ir,
   input  logic [WIDTH-1:0] mw_o,
   input  logic [WIDTH-1:0] mw_d,
   input  logic             mw_ovf,
   output logic             we,
   output logic [AW-1:0]    addr,
   output logic [WIDTH-1:0] data
);

   logic [4:0]    opcode;
   logic [4:0]    aluop;
   logic [AW-1:0] rd;
   logic          raw_we;
   logic          unused_ir_lsb;

   assign opcode        = mw_ir[31:27];
   assign aluop         = mw_ir[6:2];
   assign rd            = AW'(mw_ir[26:22]);
   assign unused_ir_lsb = ^mw_ir[1:0];

   always_comb begin
      raw_we = 1'b0;
      addr   = '0;
      data   = '0;
      unique case (opcode)
         OP_RTYPE: begin
            // mul/div results come back later through the multdiv port
            if (aluop != ALU_MUL && aluop != ALU_DIV) begin
               raw_we = 1'b1;
               if (mw_ovf && aluop == ALU_ADD) begin
                  addr = AW'(STATUS_REG);
                  data = WIDTH'(ST_ADD_OVF);
               end else if (mw_ovf && aluop == ALU_SUB) begin
                  addr = AW'(STATUS_REG);
                  data = WIDTH'(ST_SUB_OVF);
               end else begin
                  addr = rd;
                  data = mw_o;
               end
            end
         end
         OP_ADDI: begin
            raw_we = 1'b1;
            if (mw_ovf) begin
               addr = AW'(STATUS_REG);
               data = WIDTH'(ST_ADDI_OVF);
            end else begin
               addr = rd;
               data = mw_o;
            end
         end
         OP_LW: begin
            raw_we = 1'b1;
            addr   = rd;
            data   = mw_d;
         end
         OP_JAL: begin
            raw_we = 1'b1;
            addr   = AW'(LINK_REG);
            data   = mw_o;
         end
         OP_SETX: begin
            raw_we = 1'b1;
            addr   = AW'(STATUS_REG);
            data   = WIDTH'(mw_ir[26:0]);
         end
         default: ;
      endcase
   end

   assign we = raw_we && (addr != '0);

endmodule

// File: rtl/wb_commit_ctrl.sv
// Writeback commit controller: merges pipeline writes and multdiv completions
// onto the single registered register-file write port. When both arrive in
// the same cycle the multdiv write wins, the pipeline write is parked in a
// one-entry hold buffer and the MEM/WB latch is stalled until it drains.
// Ports:
//   clock, resetn               : clock, asynchronous active-low reset
//   mw_o, mw_d, mw_ir, mw_ovf   : MEM/WB latch outputs
//   md_valid, md_result, md_exc,
//   md_rd, md_is_div            : multdiv completion (single-cycle pulse)
//   rf_we, rf_waddr, rf_wdata   : registered register-file write port
//                                 (also the forwarding copy)
//   wb_stall                    : freeze MEM/WB latch and upstream
module wb_commit_ctrl
   import wb_commit_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned AW         = 5,
   parameter int unsigned STATUS_REG = 30,
   parameter int unsigned LINK_REG   = 31
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic [WIDTH-1:0] mw_o,
   input  logic [WIDTH-1:0] mw_d,
   input  logic [31:0]      mw_ir,
   input  logic             mw_ovf,
   input  logic             md_valid,
   input  logic [WIDTH-1:0] md_result,
   input  logic             md_exc,
   input  logic [AW-1:0]    md_rd,
   input  logic             md_is_div,
   output logic             rf_we,
   output logic [AW-1:0]    rf_waddr,
   output logic [WIDTH-1:0] rf_wdata,
   output logic             wb_stall
);

   state_t           state, state_nxt;

   logic             pipe_we;
   logic [AW-1:0]    pipe_addr;
   logic [WIDTH-1:0] pipe_data;

   logic             md_we;
   logic [AW-1:0]    md_addr;
   logic [WIDTH-1:0] md_data;

   logic             buf_valid;
   logic [AW-1:0]    buf_addr;
   logic [WIDTH-1:0] buf_data;
   logic             buf_load, buf_clear;

   logic             commit_we;
   logic [AW-1:0]    commit_addr;
   logic [WIDTH-1:0] commit_data;

   wb_decode #(
      .WIDTH      (WIDTH),
      .AW         (AW),
      .STATUS_REG (STATUS_REG),
      .LINK_REG   (LINK_REG)
   ) u_decode (
      .mw_ir  (mw_ir),
      .mw_o   (mw_o),
      .mw_d   (mw_d),
      .mw_ovf (mw_ovf),
      .we     (pipe_we),
      .addr   (pipe_addr),
      .data   (pipe_data)
   );

   // An exception redirects the whole result to $rstatus.
   assign md_addr = md_exc ? AW'(STATUS_REG) : md_rd;
   assign md_data = md_exc ? (md_is_div ? WIDTH'(ST_DIV_EXC) : WIDTH'(ST_MUL_EXC))
                           : md_result;
   assign md_we   = md_valid && (md_addr != '0);

   // State register
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (pipe_we && md_we) state_nxt = HOLD;
         HOLD: if (!md_we)           state_nxt = IDLE;
         default:                    state_nxt = IDLE;
      endcase
   end

   // Output / commit selection
   always_comb begin
      commit_we   = 1'b0;
      commit_addr = '0;
      commit_data = '0;
      buf_load    = 1'b0;
      buf_clear   = 1'b0;
      unique case (state)
         IDLE: begin
            if (md_we) begin
               commit_we   = 1'b1;
               commit_addr = md_addr;
               commit_data = md_data;
               buf_load    = pipe_we;
            end else if (pipe_we) begin
               commit_we   = 1'b1;
               commit_addr = pipe_addr;
               commit_data = pipe_data;
            end
         end
         HOLD: begin
            // mw_* is ignored here: the stalled latch replays it after HOLD
            if (md_we) begin
               commit_we   = 1'b1;
               commit_addr = md_addr;
               commit_data = md_data;
            end else begin
               commit_we   = buf_valid;
               commit_addr = buf_addr;
               commit_data = buf_data;
               buf_clear   = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign wb_stall = (state == HOLD);

   // Hold buffer
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         buf_valid <= 1'b0;
         buf_addr  <= '0;
         buf_data  <= '0;
      end else if (buf_load) begin
         buf_valid <= 1'b1;
         buf_addr  <= pipe_addr;
         buf_data  <= pipe_data;
      end else if (buf_clear) begin
         buf_valid <= 1'b0;
      end
   end

   // Register-file write port; address/data only move on a commit
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         rf_we <= commit_we;
         if (commit_we) begin
            rf_waddr <= commit_addr;
            rf_wdata <= commit_data;
         end
      end
   end

endmodule

// File: tb/tb_wb_commit_ctrl.sv
module tb_wb_commit_ctrl;

   logic        clock = 1'b0;
   logic        resetn;
   logic [31:0] mw_o, mw_d, mw_ir;
   logic        mw_ovf;
   logic        md_valid;
   logic [31:0] md_result;
   logic        md_exc;
   logic [4:0]  md_rd;
   logic        md_is_div;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        wb_stall;

   int unsigned errors = 0;
   int unsigned checks = 0;

   wb_commit_ctrl #(
      .WIDTH      (32),
      .AW         (5),
      .STATUS_REG (30),
      .LINK_REG   (31)
   ) dut (
      .clock     (clock),
      .resetn    (resetn),
      .mw_o      (mw_o),
      .mw_d      (mw_d),
      .mw_ir     (mw_ir),
      .mw_ovf    (mw_ovf),
      .md_valid  (md_valid),
      .md_result (md_result),
      .md_exc    (md_exc),
      .md_rd     (md_rd),
      .md_is_div (md_is_div),
      .rf_we     (rf_we),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata),
      .wb_stall  (wb_stall)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rd,
                                       input logic [4:0] aluop);
      return {op, rd, 15'b0, aluop, 2'b00};
   endfunction

   localparam logic [31:0] NOP = {5'b11111, 27'h0};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   task automatic chk_wr(input string tag, input logic we, input logic [4:0] a,
                         input logic [31:0] d, input logic st);
      chk({tag, ".we"},    32'(rf_we),    32'(we));
      chk({tag, ".waddr"}, 32'(rf_waddr), 32'(a));
      chk({tag, ".wdata"}, rf_wdata,      d);
      chk({tag, ".stall"}, 32'(wb_stall), 32'(st));
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic md_idle();
      md_valid = 0; md_exc = 0; md_is_div = 0; md_rd = '0; md_result = '0;
   endtask

   initial begin
      resetn = 0;
      mw_o = '0; mw_d = '0; mw_ir = NOP; mw_ovf = 0;
      md_idle();
      tick();
      chk_wr("reset", 0, 0, 32'h0, 0);
      tick();
      resetn = 1;

      // add $3
      mw_ir = enc(5'b00000, 5'd3, 5'b00000); mw_o = 32'h7; mw_ovf = 0;
      tick(); chk_wr("add", 1, 3, 32'h7, 0);
      mw_ovf = 1;
      tick(); chk_wr("add_ovf", 1, 30, 32'h1, 0);
      // sub overflow
      mw_ir = enc(5'b00000, 5'd4, 5'b00001);
      tick(); chk_wr("sub_ovf", 1, 30, 32'h3, 0);
      // addi overflow
      mw_ir = enc(5'b00101, 5'd6, 5'b00000);
      tick(); chk_wr("addi_ovf", 1, 30, 32'h2, 0);
      mw_ovf = 0;
      // lw $5
      mw_ir = enc(5'b01000, 5'd5, 5'b00000); mw_d = 32'hDEAD_BEEF;
      tick(); chk_wr("lw", 1, 5, 32'hDEAD_BEEF, 0);
      // addi $0 dropped, address/data hold
      mw_ir = enc(5'b00101, 5'd0, 5'b00000); mw_o = 32'h55;
      tick(); chk_wr("addi_r0", 0, 5, 32'hDEAD_BEEF, 0);
      // R-type mul: no pipeline write
      mw_ir = enc(5'b00000, 5'd9, 5'b00110); mw_o = 32'h99;
      tick(); chk_wr("rtype_mul", 0, 5, 32'hDEAD_BEEF, 0);
      mw_ir = NOP;
      tick(); chk_wr("nop", 0, 5, 32'hDEAD_BEEF, 0);

      // jal + md conflict; mw changed during HOLD must be ignored
      mw_ir = enc(5'b00011, 5'd0, 5'b00000); mw_o = 32'h40;
      md_valid = 1; md_rd = 5'd7; md_result = 32'd42;
      tick(); chk_wr("conf_md", 1, 7, 32'd42, 1);
      md_idle();
      mw_ir = enc(5'b01000, 5'd9, 5'b00000); mw_d = 32'h1111_2222;
      tick(); chk_wr("conf_buf", 1, 31, 32'h40, 0);
      mw_ir = NOP;
      tick(); chk_wr("conf_idle", 0, 31, 32'h40, 0);

      // conflict plus second md in HOLD
      mw_ir = enc(5'b00011, 5'd0, 5'b00000); mw_o = 32'h40;
      md_valid = 1; md_rd = 5'd7; md_result = 32'd42;
      tick(); chk_wr("hold2_a", 1, 7, 32'd42, 1);
      md_rd = 5'd8; md_result = 32'd9;
      tick(); chk_wr("hold2_b", 1, 8, 32'd9, 1);
      md_idle();
      tick(); chk_wr("hold2_c", 1, 31, 32'h40, 0);
      mw_ir = NOP;

      // multdiv exceptions
      md_valid = 1; md_exc = 1; md_is_div = 1; md_rd = 5'd12; md_result = 32'h77;
      tick(); chk_wr("div_exc", 1, 30, 32'h5, 0);
      md_is_div = 0;
      tick(); chk_wr("mul_exc", 1, 30, 32'h4, 0);
      md_idle();
      // setx
      mw_ir = {5'b10101, 27'h123};
      tick(); chk_wr("setx", 1, 30, 32'h123, 0);
      mw_ir = NOP;
      tick(); chk_wr("setx_idle", 0, 30, 32'h123, 0);

      // reset during HOLD discards the buffered jal
      mw_ir = enc(5'b00011, 5'd0, 5'b00000); mw_o = 32'h80;
      md_valid = 1; md_rd = 5'd10; md_result = 32'd3;
      tick(); chk_wr("rst_pre", 1, 10, 32'd3, 1);
      #2 resetn = 0;
      #1 chk_wr("rst_async", 0, 0, 32'h0, 0);
      md_idle(); mw_ir = NOP;
      #1 resetn = 1;
      tick(); chk_wr("rst_post1", 0, 0, 32'h0, 0);
      tick(); chk_wr("rst_post2", 0, 0, 32'h0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
